// File: rtl/decode_pkg.sv
// decode_pkg: opcode/ID constants, field limits, decoded bundle
// and the pure decode function shared by the decode stage.
package decode_pkg;

   localparam logic [5:0] OP_RTYPE   = 6'd0;
   localparam logic [5:0] OP_ADDI    = 6'd1;
   localparam logic [5:0] OP_ANDI    = 6'd2;
   localparam logic [5:0] OP_MUL     = 6'd3;
   localparam logic [5:0] OP_DIV     = 6'd4;
   localparam logic [5:0] OP_ORI     = 6'd5;
   localparam logic [5:0] OP_XORI    = 6'd6;
   localparam logic [5:0] OP_SHIFT   = 6'd7;
   localparam logic [5:0] OP_LW      = 6'd8;
   localparam logic [5:0] OP_BGE     = 6'd15;
   localparam logic [5:0] OP_J       = 6'd16;
   localparam logic [5:0] OP_JR      = 6'd17;
   localparam logic [5:0] OP_JAL     = 6'd18;
   localparam logic [5:0] OP_CMP     = 6'd19;
   localparam logic [5:0] OP_LUI     = 6'd20;
   localparam logic [5:0] OP_SYSCALL = 6'd21;

   localparam logic [5:0] ID_NOP     = 6'd0;
   localparam logic [5:0] ID_ADD     = 6'd1;
   localparam logic [5:0] ID_SLL     = 6'd11;
   localparam logic [5:0] ID_JR      = 6'd22;
   localparam logic [5:0] ID_CMP     = 6'd24;
   localparam logic [5:0] ID_SYSCALL = 6'd26;

   localparam logic [5:0] FUNC_R_MAX  = 6'd3;
   localparam logic [5:0] FUNC_SH_MAX = 6'd1;

   // Operands carried at 32 bits; rs/rd are never negative,
   // so the stage can sign-extend all three to XLEN.
   typedef struct packed {
      logic [5:0]  id;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] rd;
      logic        illegal;
   } decoded_t;

   function automatic decoded_t decode_instr(
      input logic [31:0] ir
   );
      decoded_t    d;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [31:0] f_rs;
      logic [31:0] f_rt;
      logic [31:0] f_rd;
      logic [31:0] f_imm;
      logic        is_nop;
      logic        is_r3;
      logic        is_md;
      logic        is_i4;
      logic        is_i5;
      logic        is_sh;
      logic        is_cmp;
      logic        is_jmp;
      logic        is_jr;

      op     = ir[31:26];
      fn     = ir[5:0];
      f_rs   = {27'd0, ir[25:21]};
      f_rt   = {27'd0, ir[20:16]};
      f_rd   = {27'd0, ir[15:11]};
      f_imm  = {{16{ir[15]}}, ir[15:0]};

      is_nop = (ir == 32'd0);
      is_r3  = (op == OP_RTYPE) && (fn <= FUNC_R_MAX)
               && !is_nop;
      is_md  = (op == OP_MUL || op == OP_DIV)
               && (fn == 6'd0);
      is_i4  = op inside {OP_ADDI, OP_ANDI,
                          OP_ORI, OP_XORI};
      is_i5  = (op >= OP_LW && op <= OP_BGE)
               || (op == OP_LUI);
      is_sh  = (op == OP_SHIFT) && (fn <= FUNC_SH_MAX);
      is_cmp = (op == OP_CMP);
      is_jmp = op inside {OP_J, OP_JAL, OP_SYSCALL};
      is_jr  = (op == OP_JR);

      d = '0;
      unique case (1'b1)
         is_nop: d.id = ID_NOP;
         is_r3: begin
            d.id = ID_ADD + fn;
            d.rs = f_rs;
            d.rt = f_rt;
            d.rd = f_rd;
         end
         is_md: begin
            d.id = op + 6'd4;
            d.rs = f_rs;
            d.rt = f_rt;
            d.rd = f_rd;
         end
         is_i4: begin
            d.id = op + 6'd4;
            d.rs = f_rs;
            d.rt = f_imm;
            d.rd = f_rt;
         end
         is_i5: begin
            d.id = op + 6'd5;
            d.rs = f_rs;
            d.rt = f_imm;
            d.rd = f_rt;
         end
         is_sh: begin
            d.id = ID_SLL + fn;
            d.rs = f_rt;
            d.rt = {27'd0, ir[10:6]};
            d.rd = f_rd;
         end
         is_cmp: begin
            d.id = ID_CMP;
            d.rs = f_rs;
            d.rt = f_rt;
            d.rd = f_rd;
         end
         is_jmp: begin
            d.id = op + 6'd5;
            d.rs = {6'd0, ir[25:0]};
         end
         is_jr: begin
            d.id = ID_JR;
            d.rs = f_rs;
         end
         default: d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch->decode and decode->execute handshakes.
// master = fetch/execute side, slave = decode stage.
interface decode_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;
   logic            out_valid;
   logic            out_ready;
   logic [5:0]      out_id;
   logic [XLEN-1:0] out_rs;
   logic [XLEN-1:0] out_rt;
   logic [XLEN-1:0] out_rd;
   logic [XLEN-1:0] out_pc;
   logic            out_illegal;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_id, out_rs,
      input  out_rt, out_rd, out_pc, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_id, out_rs,
      output out_rt, out_rd, out_pc, out_illegal
   );
endinterface

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO. Ports: clk, reset, clr (flush),
// push/wdata, pop/rdata (head), full, empty, count.
module instr_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d   = mem_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (clr) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + AW'(1);
         end
         if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
         end
         count_d = count_q
                   + (AW+1)'(do_push)
                   - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: FIFO-buffered decoder with registered valid/ready output.
// Ports: clk, reset, flush, io (decode_stage_if.slave), fifo_count; DECODE_STATS_EN adds stat_decoded/stat_illegal.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   decode_stage_if.slave                io,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count
`ifdef DECODE_STATS_EN
   ,
   output logic [CNT_W-1:0]             stat_decoded,
   output logic [CNT_W-1:0]             stat_illegal
`endif
);
   localparam int FW = XLEN + 32;

   logic          push, pop, full, empty;
   logic [FW-1:0] head;
   decoded_t      dec;

   logic            out_valid_q, out_valid_d;
   logic [5:0]      out_id_q, out_id_d;
   logic [XLEN-1:0] out_rs_q, out_rs_d;
   logic [XLEN-1:0] out_rt_q, out_rt_d;
   logic [XLEN-1:0] out_rd_q, out_rd_d;
   logic [XLEN-1:0] out_pc_q, out_pc_d;
   logic            out_illegal_q, out_illegal_d;

   // Flush blocks both sides so nothing enters or leaves
   // the buffer in the cycle it is being emptied.
   assign push = io.in_valid && !full && !flush;
   assign pop  = !empty && !flush
                 && (!out_valid_q || io.out_ready);

   assign io.in_ready = !full;

   instr_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .push  (push),
      .wdata ({io.in_pc, io.in_instr}),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   assign dec = decode_instr(head[31:0]);

   always_comb begin
      out_valid_d   = out_valid_q;
      out_id_d      = out_id_q;
      out_rs_d      = out_rs_q;
      out_rt_d      = out_rt_q;
      out_rd_d      = out_rd_q;
      out_pc_d      = out_pc_q;
      out_illegal_d = out_illegal_q;
      if (flush) begin
         out_valid_d   = 1'b0;
         out_id_d      = '0;
         out_rs_d      = '0;
         out_rt_d      = '0;
         out_rd_d      = '0;
         out_pc_d      = '0;
         out_illegal_d = 1'b0;
      end else if (pop) begin
         out_valid_d   = 1'b1;
         out_id_d      = dec.id;
         out_rs_d      = XLEN'($signed(dec.rs));
         out_rt_d      = XLEN'($signed(dec.rt));
         out_rd_d      = XLEN'($signed(dec.rd));
         out_pc_d      = head[FW-1:32];
         out_illegal_d = dec.illegal;
      end else if (io.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q   <= 1'b0;
         out_id_q      <= '0;
         out_rs_q      <= '0;
         out_rt_q      <= '0;
         out_rd_q      <= '0;
         out_pc_q      <= '0;
         out_illegal_q <= 1'b0;
      end else begin
         out_valid_q   <= out_valid_d;
         out_id_q      <= out_id_d;
         out_rs_q      <= out_rs_d;
         out_rt_q      <= out_rt_d;
         out_rd_q      <= out_rd_d;
         out_pc_q      <= out_pc_d;
         out_illegal_q <= out_illegal_d;
      end
   end

   assign io.out_valid   = out_valid_q;
   assign io.out_id      = out_id_q;
   assign io.out_rs      = out_rs_q;
   assign io.out_rt      = out_rt_q;
   assign io.out_rd      = out_rd_q;
   assign io.out_pc      = out_pc_q;
   assign io.out_illegal = out_illegal_q;

`ifdef DECODE_STATS_EN
   logic [CNT_W-1:0] stat_decoded_q, stat_decoded_d;
   logic [CNT_W-1:0] stat_illegal_q, stat_illegal_d;

   always_comb begin
      stat_decoded_d = stat_decoded_q;
      stat_illegal_d = stat_illegal_q;
      if (pop && dec.id != ID_NOP) begin
         stat_decoded_d = stat_decoded_q + CNT_W'(1);
      end
      if (pop && dec.illegal) begin
         stat_illegal_d = stat_illegal_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_decoded_q <= '0;
         stat_illegal_q <= '0;
      end else begin
         stat_decoded_q <= stat_decoded_d;
         stat_illegal_q <= stat_illegal_d;
      end
   end

   assign stat_decoded = stat_decoded_q;
   assign stat_illegal = stat_illegal_q;
`else
   logic [CNT_W-1:0] stat_unused;
   assign stat_unused = '0;
`endif

endmodule
